// File: rtl/ransac_pio_cmd_ctrl.sv
// ransac_pio_cmd_ctrl
// Turns the software run/stop level coming from the NIOS output PIO into a
// one-cycle start / abort handshake for the RANSAC accelerator. It also times
// each job in clk cycles and keeps busy/done/timeout status for PIO readback.
// Every output is a flop, so the status word is glitch-free.
// reset_n is the system reset. It already has a synchronous deassertion edge,
// so it is used here directly as an asynchronous clear.

module ransac_pio_cmd_ctrl #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_level,
  output logic             acc_start,
  output logic             acc_abort,
  input  logic             acc_done,
  output logic             busy,
  output logic             done_flag,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic             cmd_q;
  logic             acc_start_q;
  logic             acc_abort_q;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic [CNT_W-1:0] count_q;

  logic             cmd_rise;
  logic [CNT_W-1:0] count_d;
  logic             timeout_hit;

  // Rising edge of the software level. cmd_q clears on reset, so a level
  // that is already high when reset ends starts exactly one job.
  assign cmd_rise = cmd_level & ~cmd_q;

  // Saturating increment, and a timeout test against that incremented value.
  assign count_d     = (&count_q) ? count_q : count_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (count_d == TIMEOUT_C);

  // Control FSM. All handshake and status outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= 1'b0;
      acc_start_q <= 1'b0;
      acc_abort_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      cmd_q       <= cmd_level;
      acc_start_q <= 1'b0;
      acc_abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Results of the previous job stay readable until the next start.
          if (cmd_rise) begin
            state_q     <= S_START;
            acc_start_q <= 1'b1;
            busy_q      <= 1'b1;
            count_q     <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        S_START: begin
          // Start pulse lasts one cycle. acc_done is not looked at yet.
          state_q <= S_RUN;
        end
        S_RUN: begin
          // Completion beats a cancel in the same cycle, and a cancel beats timeout.
          if (acc_done) begin
            count_q <= count_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else if (!cmd_level) begin
            acc_abort_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else if (timeout_hit) begin
            count_q     <= count_d;
            timeout_q   <= 1'b1;
            acc_abort_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            count_q <= count_d;
          end
        end
        S_DONE: begin
          // Wait for software to drop the level; a new job needs a fresh rise.
          if (!cmd_level) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign acc_start    = acc_start_q;
  assign acc_abort    = acc_abort_q;
  assign busy         = busy_q;
  assign done_flag    = done_q;
  assign timeout_flag = timeout_q;
  assign cycle_count  = count_q;

endmodule

// File: tb/tb_ransac_pio_cmd_ctrl.sv
// Testbench for ransac_pio_cmd_ctrl.
// A job-level reference model predicts all outputs of the main instance
// (TIMEOUT=16, CNT_W=8). A compare process checks the DUT against the model
// on every falling edge. Directed sequences also pin hand-computed literals.
// A second instance with timeout disabled covers counter saturation.

module tb_ransac_pio_cmd_ctrl;

  localparam int          CW  = 8;
  localparam int unsigned TO  = 16;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic          cmd_level;
  logic          acc_done;
  logic          acc_start;
  logic          acc_abort;
  logic          busy;
  logic          done_flag;
  logic          timeout_flag;
  logic [CW-1:0] cycle_count;

  logic          cmd2;
  logic          done2;
  logic          start2;
  logic          abort2;
  logic          busy2;
  logic          dflag2;
  logic          tflag2;
  logic [CW-1:0] count2;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_starts = 0;

  ransac_pio_cmd_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_level    (cmd_level),
    .acc_start    (acc_start),
    .acc_abort    (acc_abort),
    .acc_done     (acc_done),
    .busy         (busy),
    .done_flag    (done_flag),
    .timeout_flag (timeout_flag),
    .cycle_count  (cycle_count)
  );

  ransac_pio_cmd_ctrl #(.CNT_W(CW), .TIMEOUT(0)) dut_nto (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_level    (cmd2),
    .acc_start    (start2),
    .acc_abort    (abort2),
    .acc_done     (done2),
    .busy         (busy2),
    .done_flag    (dflag2),
    .timeout_flag (tflag2),
    .cycle_count  (count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, described in terms of jobs:
  // - m_job: a job is in progress (start cycle or running cycles).
  // - m_first: the first cycle of a job, which is the start-pulse cycle.
  // - m_wait: the job finished, and the model waits for software to drop the level.
  // - m_cnt: the number of running cycles counted so far (saturating).
  logic m_job, m_first, m_wait, m_abort, m_done, m_to, m_cmd_prev;
  int   m_cnt;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_job <= 1'b0; m_first <= 1'b0; m_wait <= 1'b0; m_abort <= 1'b0;
      m_done <= 1'b0; m_to <= 1'b0; m_cmd_prev <= 1'b0; m_cnt <= 0;
    end else begin
      m_cmd_prev <= cmd_level;
      m_abort    <= 1'b0;
      if (!m_job && !m_wait) begin
        if (cmd_level && !m_cmd_prev) begin
          m_job <= 1'b1; m_first <= 1'b1; m_cnt <= 0; m_done <= 1'b0; m_to <= 1'b0;
        end
      end else if (m_first) begin
        m_first <= 1'b0;
      end else if (m_job) begin
        if (acc_done) begin
          m_cnt <= sat_inc(m_cnt); m_done <= 1'b1; m_job <= 1'b0; m_wait <= 1'b1;
        end else if (!cmd_level) begin
          m_abort <= 1'b1; m_job <= 1'b0;
        end else if (m_cnt + 1 == int'(TO)) begin
          m_cnt <= m_cnt + 1; m_to <= 1'b1; m_abort <= 1'b1; m_job <= 1'b0; m_wait <= 1'b1;
        end else begin
          m_cnt <= sat_inc(m_cnt);
        end
      end else if (!cmd_level) begin
        m_wait <= 1'b0;
      end
    end
  end

  // Compare the DUT with the model on every falling edge.
  always @(negedge clk) begin
    check("acc_start",    32'(acc_start),    32'(m_first));
    check("acc_abort",    32'(acc_abort),    32'(m_abort));
    check("busy",         32'(busy),         32'(m_job));
    check("done_flag",    32'(done_flag),    32'(m_done));
    check("timeout_flag", 32'(timeout_flag), 32'(m_to));
    check("cycle_count",  32'(cycle_count),  32'(m_cnt));
    check("start_abort_excl", 32'(acc_start & acc_abort), 32'd0);
  end

  // Count start pulses. A pulse is counted once, at the edge that ends its cycle.
  always @(posedge clk) begin
    if (acc_start) n_starts <= n_starts + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; cmd_level = 1'b0; acc_done = 1'b0; cmd2 = 1'b0; done2 = 1'b0;
    step(2);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_flags", 32'({done_flag, timeout_flag, acc_start, acc_abort}), 32'd0);
    reset_n = 1'b1;
    step(2);

    // 1) acc_done arrives in the 5th running cycle.
    cmd_level = 1'b1;
    step(1);
    check("t1_start", 32'(acc_start), 32'd1);
    check("t1_busy",  32'(busy),      32'd1);
    step(5);
    acc_done = 1'b1;
    step(1);
    acc_done = 1'b0;
    check("t1_count", 32'(cycle_count), 32'd5);
    check("t1_done",  32'(done_flag),   32'd1);
    check("t1_busy0", 32'(busy),        32'd0);
    check("t1_nstart", 32'(n_starts),   32'd1);
    cmd_level = 1'b0;
    step(2);
    check("t1_persist", 32'(cycle_count), 32'd5);

    // 2) No acc_done: the timeout fires after 16 running cycles.
    cmd_level = 1'b1;
    step(18);
    check("t2_abort", 32'(acc_abort),    32'd1);
    check("t2_to",    32'(timeout_flag), 32'd1);
    check("t2_done",  32'(done_flag),    32'd0);
    check("t2_count", 32'(cycle_count),  32'd16);
    step(1);
    check("t2_abort_1cyc", 32'(acc_abort), 32'd0);
    cmd_level = 1'b0;
    step(2);

    // 3) Software cancel in the 3rd running cycle.
    cmd_level = 1'b1;
    step(4);
    cmd_level = 1'b0;
    step(1);
    check("t3_abort", 32'(acc_abort),   32'd1);
    check("t3_count", 32'(cycle_count), 32'd2);
    check("t3_flags", 32'({done_flag, timeout_flag}), 32'd0);
    check("t3_busy",  32'(busy),        32'd0);
    step(2);

    // 4) acc_done and a cancel in the same cycle: completion wins.
    cmd_level = 1'b1;
    step(3);
    acc_done = 1'b1; cmd_level = 1'b0;
    step(1);
    acc_done = 1'b0;
    check("t4_done",  32'(done_flag),   32'd1);
    check("t4_abort", 32'(acc_abort),   32'd0);
    check("t4_count", 32'(cycle_count), 32'd2);
    step(1);
    cmd_level = 1'b1;
    step(1);
    check("t4_restart", 32'(acc_start), 32'd1);
    cmd_level = 1'b0;
    step(3);

    // 5) Level held high after completion, then a 1->0->1 sequence.
    n_starts = 0;
    cmd_level = 1'b1;
    step(2);
    acc_done = 1'b1;
    step(1);
    acc_done = 1'b0;
    check("t5_count", 32'(cycle_count), 32'd1);
    step(5);
    check("t5_hold_nstart", 32'(n_starts),  32'd1);
    check("t5_hold_done",   32'(done_flag), 32'd1);
    cmd_level = 1'b0;
    step(1);
    cmd_level = 1'b1;
    step(1);
    check("t5_start",   32'(acc_start),   32'd1);
    check("t5_cleared", 32'(done_flag),   32'd0);
    check("t5_count0",  32'(cycle_count), 32'd0);
    step(2);
    check("t5_nstart",  32'(n_starts),    32'd2);
    acc_done = 1'b1;
    step(1);
    acc_done = 1'b0;
    cmd_level = 1'b0;
    step(2);

    // 6) Reset asserted in the middle of a job, with cmd kept high.
    cmd_level = 1'b1;
    step(4);
    #2 reset_n = 1'b0;
    #1;
    check("t6_busy",  32'(busy),        32'd0);
    check("t6_count", 32'(cycle_count), 32'd0);
    check("t6_pulse", 32'({acc_start, acc_abort}), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    check("t6_newstart", 32'(acc_start), 32'd1);
    step(3);
    check("t6_run_count", 32'(cycle_count), 32'd2);
    cmd_level = 1'b0;
    step(2);

    // Timeout disabled: the counter saturates at its all-ones value.
    cmd2 = 1'b1;
    step(300);
    check("sat_count", 32'(count2), 32'(SAT));
    check("sat_busy",  32'(busy2),  32'd1);
    check("sat_noto",  32'({tflag2, abort2}), 32'd0);
    done2 = 1'b1;
    step(1);
    done2 = 1'b0;
    check("sat_done",       32'(dflag2), 32'd1);
    check("sat_done_count", 32'(count2), 32'(SAT));
    cmd2 = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
